regfile_mp: RTL
===============

# regfile_mp

Parametrised multi-read-port integer register file, the successor to the single-cycle core's 2R1W file. It supports a configurable number of registers, data width and read ports, with x0 hardwired to zero. It adds a hardware clear sequencer that zeroes every register after reset or on request, plus optional write-to-read bypass. It sits in the decode/writeback path of the pipelined core and keeps a debug read port for the testbench and trace logic.

## Interface
Parameters:
- XLEN, 32, data width in bits
- NREG, 32, number of architectural registers; power of two, ≥ 4
- NRD, 2, number of read ports, 1..4
- AW, $clog2(NREG), address width (derived, not overridden)

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- clr_req  in  1  request full clear while running
- ready  out  1  high when the file is cleared and accepting writes
- wen  in  1  write enable
- waddr  in  AW  write address
- wdata  in  XLEN  write data
- raddr  in  NRD*AW  packed read addresses; port i at [i*AW +: AW]
- rdata  out  NRD*XLEN  packed read data; port i at [i*XLEN +: XLEN]
- debug_raddr  in  AW  debug read address
- debug_reg  out  XLEN  debug read data

## Operation
- States: INIT (clearing), RUN.
- Reset:
  - At a clock edge with rst=1: state←INIT, clear index cnt←1, ready←0.
  - Array contents are not touched by reset itself.
- INIT:
  - Each edge with rst=0 writes regs[cnt]←0 and increments cnt.
  - On the edge that clears regs[NREG-1], state←RUN and ready←1.
  - wen is ignored; the write is dropped and not queued.
- RUN:
  - On an edge with wen=1 and waddr≠0, regs[waddr]←wdata.
  - Writes to address 0 are discarded.
- clr_req:
  - If clr_req=1 at an edge in RUN, state←INIT, cnt←1, ready←0, and any same-cycle write is dropped.
  - If clr_req=1 at an edge in INIT, the sequence restarts with cnt←1.
  - rst has priority over clr_req.
- Reads:
  - Combinational. Read data for address 0 is always 0.
  - While ready=0, all rdata and debug_reg are forced to 0.
- Multiple read ports may name the same address; each port returns identical data.
- The debug port never uses bypass; it always shows the stored value.

## Timing
- Read latency is 0 cycles (combinational from raddr). Write latency is 1 edge.
- After the last edge with rst=1, ready rises after NREG-1 further edges (31 for NREG=32). The clear sequence lasts the same number of edges after clr_req.
- Values on outputs during and after reset:
  - ready=0.
  - rdata=0 and debug_reg=0 until ready=1.
- Same-cycle write and read to the same address: behaviour depends on REGFILE_BYPASS_EN; see Configuration.
- cnt wraps only through the INIT→RUN transition. No other wrap-around exists.

## Configuration
- REGFILE_BYPASS_EN defined:
  - In RUN, when wen=1, waddr≠0, clr_req=0 and raddr_i==waddr, rdata_i = wdata in the same cycle (write-through).
- REGFILE_BYPASS_EN undefined:
  - rdata_i returns the old stored value until the write edge.
  - The pipeline must cover the hazard with a forwarding unit.

## Structure
- A shared package, regfile_pkg, holds:
  - the state enum (INIT, RUN)
  - the default XLEN/NREG constants
  - the AW derivation
- One sub-module, regfile_init_ctrl, holds the INIT/RUN FSM, cnt and ready. It outputs a clear-write enable and address.
- The top level muxes the clear write and the user write into the single array write port, with the clear write having priority.

## Test plan
- Reset then ready:
  - Stimulus: hold rst=1 for 3 edges, release, NREG=32.
  - Required response: ready=0 for 30 edges, ready=1 after the 31st. Reading every address returns 0.
- Basic write/read:
  - Stimulus: in RUN, write 0xDEADBEEF to x5, then read x5 on ports 0 and 1 and on debug.
  - Required response: all three return 0xDEADBEEF on the next cycle.
- x0 write:
  - Stimulus: write 0x12345678 to x0.
  - Required response: every port reading x0 returns 0.
- Same-cycle write/read:
  - Stimulus: x7 holds 0x1; drive wen=1, waddr=7, wdata=0x2 with raddr0=7.
  - Required response: rdata0=0x2 with REGFILE_BYPASS_EN, 0x1 without; debug_reg=0x1 either way. Both read 0x2 after the edge.
- clr_req in RUN:
  - Stimulus: write 0xAA to x3, assert clr_req together with wen to x4=0xBB for one cycle.
  - Required response: ready drops, x4 is never written, x3 reads 0 once ready returns after 31 edges.
- Reset mid-clear:
  - Stimulus: assert rst at cnt=10 during INIT.
  - Required response: the sequence restarts and ready rises 31 edges after rst is released. Writes during INIT are dropped.

Source files
------------

// File: rtl/regfile_pkg.sv
// rtl/regfile_pkg.sv - shared state enum, default sizes and address-width helper for regfile_mp
package regfile_pkg;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } rf_state_e;

  localparam int XLEN_DEF = 32;
  localparam int NREG_DEF = 32;

  function automatic int addr_width(input int nreg);
    return (nreg > 1) ? $clog2(nreg) : 1;
  endfunction

  localparam int AW_DEF = addr_width(NREG_DEF);

endpackage

// File: rtl/regfile_init_ctrl.sv
// rtl/regfile_init_ctrl.sv - INIT/RUN sequencer that walks x1..x(NREG-1) writing zero, then raises ready
module regfile_init_ctrl
  import regfile_pkg::*;
#(
  parameter int  NREG = NREG_DEF,
  localparam int AW   = addr_width(NREG)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr_req,
  output logic          ready,
  output logic          clr_we,
  output logic [AW-1:0] clr_addr
);

  localparam logic [AW-1:0] ONE  = AW'(1);
  localparam logic [AW-1:0] LAST = AW'(NREG - 1);

  rf_state_e     state_q, state_d;
  logic [AW-1:0] cnt_q, cnt_d;

  // State and clear index; x0 is never stored so the walk starts at 1
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_INIT;
      cnt_q   <= ONE;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next state: a clear request restarts the walk, INIT zeroes one register per edge
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    clr_we  = 1'b0;
    if (clr_req) begin
      state_d = ST_INIT;
      cnt_d   = ONE;
    end else if (state_q == ST_INIT) begin
      clr_we = ~rst;
      cnt_d  = cnt_q + ONE;
      if (cnt_q == LAST) begin
        state_d = ST_RUN;
      end
    end
  end

  assign clr_addr = cnt_q;
  assign ready    = (state_q == ST_RUN);

endmodule

// File: rtl/regfile_mp.sv
// rtl/regfile_mp.sv - multi-read-port register file with clear sequencer; REGFILE_BYPASS_EN enables write-through
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int  XLEN = XLEN_DEF,
  parameter int  NREG = NREG_DEF,
  parameter int  NRD  = 2,
  localparam int AW   = addr_width(NREG)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                clr_req,
  output logic                ready,
  input  logic                wen,
  input  logic [AW-1:0]       waddr,
  input  logic [XLEN-1:0]     wdata,
  input  logic [NRD*AW-1:0]   raddr,
  output logic [NRD*XLEN-1:0] rdata,
  input  logic [AW-1:0]       debug_raddr,
  output logic [XLEN-1:0]     debug_reg
);

  logic            clr_we;
  logic [AW-1:0]   clr_addr;
  logic            user_hit;
  logic            user_we;
  logic [XLEN-1:0] regs_q [NREG];

  regfile_init_ctrl #(
    .NREG(NREG)
  ) u_init_ctrl (
    .clk     (clk),
    .rst     (rst),
    .clr_req (clr_req),
    .ready   (ready),
    .clr_we  (clr_we),
    .clr_addr(clr_addr)
  );

  // A user write that will land at this edge (also the bypass qualifier)
  assign user_hit = ready & wen & (waddr != '0) & ~clr_req;
  assign user_we  = user_hit & ~rst;

  // Single array write port; the clear sequencer wins over user writes
  always_ff @(posedge clk) begin
    if (clr_we) begin
      regs_q[clr_addr] <= '0;
    end else if (user_we) begin
      regs_q[waddr] <= wdata;
    end
  end

  for (genvar g = 0; g < NRD; g++) begin : g_rd
    logic [AW-1:0] ra;
    logic          fwd;
    assign ra = raddr[g*AW +: AW];
`ifdef REGFILE_BYPASS_EN
    assign fwd = user_hit && (ra == waddr);
`else
    assign fwd = 1'b0;
`endif
    assign rdata[g*XLEN +: XLEN] = (!ready || ra == '0) ? '0 :
                                   fwd ? wdata : regs_q[ra];
  end

  assign debug_reg = (!ready || debug_raddr == '0) ? '0 : regs_q[debug_raddr];

endmodule
